// File: rtl/debounce_array_pkg.sv
// Shared definitions for the button debouncer: hold-FSM states, the counter-width helper
// and the board timing constants at 125 MHz.
package debounce_array_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_state_t;

  localparam int DEB_10MS  = 1250000;
  localparam int LONG_1S   = 125000000;
  localparam int REP_200MS = 25000000;

  // Width of a counter that must reach the larger of two terminal counts.
  function automatic int clog2_max(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, polarity normalisation, debounce counter
// and the IDLE/HELD/LONG hold FSM producing press/release/long/repeat pulses.
module debounce_channel
  import debounce_array_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = DEB_10MS,
  parameter int LONG_CYCLES     = LONG_1S,
  parameter int REPEAT_CYCLES   = REP_200MS
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = clog2_max(LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic          sync1;
  logic          sync2;
  logic          pressed;
  logic          stable;
  logic          accept;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  hold_state_t   state;

  // Synchroniser resets to the idle pin level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  assign pressed = sync2 ^ ACTIVE_LOW;
  assign stable  = (sync1 == sync2);
  assign accept  = en && stable && (pressed != level) && (dcnt == DEB_LAST);

  // A release wins over any long/repeat pulse that would land in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt          <= '0;
      hcnt          <= '0;
      state         <= IDLE;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      if (!en) begin
        dcnt <= '0;
        hcnt <= '0;
      end else begin
        if (!stable || (pressed == level)) begin
          dcnt <= '0;
        end else if (dcnt == DEB_LAST) begin
          dcnt  <= '0;
          level <= pressed;
        end else begin
          dcnt <= dcnt + DW'(1);
        end

        if (accept && pressed) begin
          press_pulse <= 1'b1;
          state       <= HELD;
          hcnt        <= '0;
        end else if (accept) begin
          release_pulse <= 1'b1;
          state         <= IDLE;
          hcnt          <= '0;
        end else begin
          case (state)
            IDLE: hcnt <= '0;
            HELD: begin
              if (hcnt == LONG_LAST) begin
                long_pulse <= 1'b1;
                hcnt       <= '0;
                state      <= LONG;
              end else begin
                hcnt <= hcnt + HW'(1);
              end
            end
            LONG: begin
              if (REPEAT_CYCLES == 0) begin
                hcnt <= '0;
              end else if (hcnt == REP_LAST) begin
                repeat_pulse <= 1'b1;
                hcnt         <= '0;
              end else begin
                hcnt <= hcnt + HW'(1);
              end
            end
            default: begin
              state <= IDLE;
              hcnt  <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/debounce_array.sv
// N-channel push-button debouncer and event generator; each channel is an
// independent debounce_channel instance.
module debounce_array
  import debounce_array_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = DEB_10MS,
  parameter int LONG_CYCLES     = LONG_1S,
  parameter int REPEAT_CYCLES   = REP_200MS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  // Polarity is normalised inside each channel, after its synchroniser.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .btn           (btn_in[i]),
      .level         (level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_debounce_array.sv
// Directed bench for debounce_array: two copies share the stimulus, one with
// auto-repeat every 5 cycles and one with auto-repeat disabled.
module tb_debounce_array;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [1:0] btn_in = 2'b11;

  logic [1:0] level, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic [1:0] level_nr, press_nr, release_nr, long_nr, repeat_nr;

  int checks = 0;
  int passes = 0;
  int norep_repeats = 0;

  always #5 clk = ~clk;

  debounce_array #(
    .N_CH(2), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(5)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .btn_in(btn_in),
    .level(level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  debounce_array #(
    .N_CH(2), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(0)
  ) dut_norep (
    .clk(clk), .rst(rst), .en(en), .btn_in(btn_in),
    .level(level_nr), .press_pulse(press_nr), .release_pulse(release_nr),
    .long_pulse(long_nr), .repeat_pulse(repeat_nr)
  );

  always @(negedge clk) begin
    if (repeat_nr != 2'b00) norep_repeats++;
  end

  function automatic logic [9:0] ev(input logic [1:0] lv, input logic [1:0] pr,
                                    input logic [1:0] rl, input logic [1:0] lg,
                                    input logic [1:0] rp);
    return {lv, pr, rl, lg, rp};
  endfunction

  function automatic logic [9:0] outs();
    return {level, press_pulse, release_pulse, long_pulse, repeat_pulse};
  endfunction

  function automatic logic [9:0] outs_nr();
    return {level_nr, press_nr, release_nr, long_nr, repeat_nr};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    else passes++;
  endtask

  // Drive the pins just after an edge, then advance n edges and settle 1 time unit.
  task automatic applyStimulus(input logic [1:0] pins, input int n);
    btn_in = pins;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [13:0] bounce;
  logic [1:0]  cur;
  logic [1:0]  rep;

  initial begin
    #1;
    checkOutput("in_reset", 32'(outs()), 32'(ev(0, 0, 0, 0, 0)));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(2'b11, 10);
    checkOutput("reset_idle", 32'(outs()), 32'(ev(0, 0, 0, 0, 0)));
    checkOutput("reset_idle_nr", 32'(outs_nr()), 32'(ev(0, 0, 0, 0, 0)));

    // ch0 bounces: low 3, high 1, low 3, then high; pattern bit i drives cycle i
    bounce = 14'b11111110001000;
    for (int i = 0; i < 14; i++) begin
      applyStimulus({1'b1, bounce[i]}, 1);
      checkOutput($sformatf("bounce_c%0d", i), 32'(outs()), 32'(ev(0, 0, 0, 0, 0)));
    end

    applyStimulus(2'b10, 5);
    checkOutput("press_t5", 32'(outs()), 32'(ev(0, 0, 0, 0, 0)));
    applyStimulus(2'b10, 1);
    checkOutput("press_t6", 32'(outs()), 32'(ev(2'b01, 2'b01, 0, 0, 0)));

    cur = 2'b10;
    for (int c = 1; c <= 62; c++) begin
      applyStimulus(cur, 1);
      rep = (c > 20 && c < 60 && ((c - 20) % 5) == 0) ? 2'b01 : 2'b00;
      checkOutput($sformatf("hold_c%0d", c), 32'(outs()),
                  32'(ev((c < 60) ? 2'b01 : 2'b00, 0, (c == 60) ? 2'b01 : 2'b00,
                         (c == 20) ? 2'b01 : 2'b00, rep)));
      checkOutput($sformatf("hold_nr_c%0d", c), 32'(outs_nr()),
                  32'(ev((c < 60) ? 2'b01 : 2'b00, 0, (c == 60) ? 2'b01 : 2'b00,
                         (c == 20) ? 2'b01 : 2'b00, 0)));
      if (c == 54) cur = 2'b11;
    end

    applyStimulus(2'b00, 6);
    checkOutput("dual_press", 32'(outs()), 32'(ev(2'b11, 2'b11, 0, 0, 0)));
    applyStimulus(2'b10, 6);
    checkOutput("ch1_release", 32'(outs()), 32'(ev(2'b01, 0, 2'b10, 0, 0)));
    for (int c = 7; c <= 20; c++) begin
      applyStimulus(2'b10, 1);
      checkOutput($sformatf("long_c%0d", c), 32'(outs()),
                  32'(ev(2'b01, 0, 0, (c == 20) ? 2'b01 : 2'b00, 0)));
    end

    en = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(2'b10, 1);
      checkOutput($sformatf("frozen_c%0d", c), 32'(outs()), 32'(ev(2'b01, 0, 0, 0, 0)));
    end
    en = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(2'b10, 1);
      checkOutput($sformatf("resume_c%0d", c), 32'(outs()),
                  32'(ev(2'b01, 0, 0, 0, (c == 5) ? 2'b01 : 2'b00)));
    end

    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_rst", 32'(outs()), 32'(ev(0, 0, 0, 0, 0)));
    checkOutput("async_rst_nr", 32'(outs_nr()), 32'(ev(0, 0, 0, 0, 0)));
    @(posedge clk);
    #1;
    checkOutput("rst_no_release", 32'(outs()), 32'(ev(0, 0, 0, 0, 0)));
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(2'b10, 1);
      checkOutput($sformatf("repress_c%0d", c), 32'(outs()),
                  32'(ev((c == 6) ? 2'b01 : 2'b00, (c == 6) ? 2'b01 : 2'b00, 0, 0, 0)));
    end
    checkOutput("repress_nr", 32'(outs_nr()), 32'(ev(2'b01, 2'b01, 0, 0, 0)));

    checkOutput("norep_repeat_count", 32'(norep_repeats), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
